// File: rtl/bit16_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Imported by the subtractor top and its slice datapath.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nslices(int w, int s);
    return w / s;
  endfunction

  function automatic int cnt_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int WIDTH_D = 16;
  localparam int SLICE_D = 4;
  localparam int N_D     = nslices(WIDTH_D, SLICE_D);

endpackage

// File: rtl/bit16_serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// Optional zero flag: BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
interface bit16_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );
`endif
endinterface

// File: rtl/bit16_serial_subtractor_sub_slice.sv
// Combinational W-bit ripple-borrow subtractor.
// Built as a chain of full-subtractor cells.
module sub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign diff[i]  = x[i] ^ y[i] ^ br[i];
    assign br[i+1]  = (~x[i] & y[i])
                    | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bout = br[W];

endmodule

// File: rtl/bit16_serial_subtractor.sv
// Multi-cycle d = a - b - bin, SLICE bits per clock.
// Optional zero flag: BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
module bit16_serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic clk,
  input logic rst,
  bit16_serial_subtractor_if.slave bus
);

  localparam int N  = nslices(WIDTH, SLICE);
  localparam int CW = cnt_w(N);

  state_t           state;
  state_t           nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             br;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;
  logic             in_rdy;
  logic             out_vld;
  logic             last;
  logic [SLICE-1:0] sx;
  logic [SLICE-1:0] sy;
  logic [SLICE-1:0] sd;
  logic             sbo;

  assign sx   = ra[cnt*SLICE +: SLICE];
  assign sy   = rb[cnt*SLICE +: SLICE];
  assign last = (cnt == CW'(N - 1));

  sub_slice #(
    .W (SLICE)
  ) u_slice (
    .x    (sx),
    .y    (sy),
    .bin  (br),
    .diff (sd),
    .bout (sbo)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next state and handshake outputs
  always_comb begin
    nstate  = state;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) nstate = RUN;
      end
      RUN: begin
        if (last) nstate = DONE;
      end
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Operand capture and slice-by-slice result build
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra  <= bus.a;
            rb  <= bus.b;
            br  <= bus.bin;
            cnt <= '0;
            d_q <= '0;
          end
        end
        RUN: begin
          d_q[cnt*SLICE +: SLICE] <= sd;
          br  <= sbo;
          cnt <= cnt + CW'(1);
          if (last) begin
            bout_q <= sbo;
            ovf_q  <= (ra[WIDTH-1] != rb[WIDTH-1])
                   && (sd[SLICE-1] != ra[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic zacc;
  logic zero_q;

  // Accumulate nonzero slices; flag lands with the last slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zacc   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        zacc <= 1'b0;
      end else if (state == RUN) begin
        zacc <= zacc | (|sd);
        if (last) zero_q <= ~(zacc | (|sd));
      end
    end
  end

  assign bus.zero = zero_q;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bit16_serial_subtractor.sv
// Scoreboard bench for the serial subtractor.
// Covers SLICE=4 (main), 1 and 16 (sweep).
module tb_bit16_serial_subtractor;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errs;

  res_t q4[$];
  res_t q1[$];
  res_t q16[$];

  bit16_serial_subtractor_if #(.WIDTH(16)) i4 ();
  bit16_serial_subtractor_if #(.WIDTH(16)) i1 ();
  bit16_serial_subtractor_if #(.WIDTH(16)) i16 ();

  bit16_serial_subtractor #(
    .WIDTH (16),
    .SLICE (4)
  ) u4 (
    .clk (clk),
    .rst (rst),
    .bus (i4)
  );

  bit16_serial_subtractor #(
    .WIDTH (16),
    .SLICE (1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (i1)
  );

  bit16_serial_subtractor #(
    .WIDTH (16),
    .SLICE (16)
  ) u16 (
    .clk (clk),
    .rst (rst),
    .bus (i16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(
    logic [15:0] a, logic [15:0] b, logic bin
  );
    res_t        r;
    logic [16:0] f;
    f      = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    r.d    = f[15:0];
    r.bout = f[16];
    r.ovf  = (a[15] != b[15]) && (r.d[15] != a[15]);
    r.zero = (r.d == 16'h0000);
    return r;
  endfunction

  function automatic res_t obs(int k);
    res_t r;
    r.d = 16'h0; r.bout = 1'b0;
    r.ovf = 1'b0; r.zero = 1'b0;
    case (k)
      0: begin
        r.d = i4.d; r.bout = i4.bout; r.ovf = i4.ovf;
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        r.zero = i4.zero;
`endif
      end
      1: begin
        r.d = i1.d; r.bout = i1.bout; r.ovf = i1.ovf;
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        r.zero = i1.zero;
`endif
      end
      default: begin
        r.d = i16.d; r.bout = i16.bout; r.ovf = i16.ovf;
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        r.zero = i16.zero;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic logic ovld(int k);
    case (k)
      0:       return i4.out_valid;
      1:       return i1.out_valid;
      default: return i16.out_valid;
    endcase
  endfunction

  function automatic res_t pop_exp(int k);
    res_t r;
    r.d = 16'h0; r.bout = 1'b0;
    r.ovf = 1'b0; r.zero = 1'b0;
    case (k)
      0:       if (q4.size() > 0)  r = q4.pop_front();
      1:       if (q1.size() > 0)  r = q1.pop_front();
      default: if (q16.size() > 0) r = q16.pop_front();
    endcase
    return r;
  endfunction

  task automatic idle_all();
    i4.in_valid = 0;  i4.out_ready = 0;
    i1.in_valid = 0;  i1.out_ready = 0;
    i16.in_valid = 0; i16.out_ready = 0;
    i4.a = 0;  i4.b = 0;  i4.bin = 0;
    i1.a = 0;  i1.b = 0;  i1.bin = 0;
    i16.a = 0; i16.b = 0; i16.bin = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);
    checks++;
    if (i4.in_ready !== 1'b1 || i4.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0",
               i4.in_ready, i4.out_valid);
    end
    checks++;
    if (i4.d !== 16'h0 || i4.bout !== 1'b0 || i4.ovf !== 1'b0) begin
      errs++;
      $display("FAIL reset_out got d=%h bo=%b ov=%b want 0",
               i4.d, i4.bout, i4.ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run4(
    string nm, logic [15:0] a, logic [15:0] b, logic bin
  );
    res_t e;
    res_t o;
    int   k;
    int   lat;
    i4.a = a; i4.b = b; i4.bin = bin;
    i4.in_valid = 1'b1;
    q4.push_back(model(a, b, bin));
    k = 0;
    while (!i4.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    i4.in_valid = 1'b0;
    lat = 0;
    while (!i4.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 4) begin
      errs++;
      $display("FAIL %s_lat got %0d want 4", nm, lat);
    end
    e = pop_exp(0);
    o = obs(0);
    checks++;
    if (o.d !== e.d || o.bout !== e.bout || o.ovf !== e.ovf) begin
      errs++;
      $display("FAIL %s got d=%h bo=%b ov=%b want d=%h bo=%b ov=%b",
               nm, o.d, o.bout, o.ovf, e.d, e.bout, e.ovf);
    end
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    checks++;
    if (o.zero !== e.zero) begin
      errs++;
      $display("FAIL %s_zero got %b want %b", nm, o.zero, e.zero);
    end
`endif
    i4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i4.out_ready = 1'b0;
  endtask

  task automatic test_arith();
    run4("sub_1234", 16'h1234, 16'h0234, 1'b0);
    run4("sub_0m1",  16'h0000, 16'h0001, 1'b0);
    run4("sub_bin",  16'h0005, 16'h0005, 1'b1);
    run4("ovf_neg",  16'h8000, 16'h0001, 1'b0);
    run4("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0);
  endtask

  task automatic test_backpressure();
    res_t e;
    int   lat;
    bit   bad;
    i4.a = 16'hABCD; i4.b = 16'hABCD; i4.bin = 1'b0;
    i4.in_valid = 1'b1;
    q4.push_back(model(16'hABCD, 16'hABCD, 1'b0));
    @(posedge clk);
    @(negedge clk);
    i4.a = 16'h0001; i4.b = 16'h0000;
    lat = 0;
    while (!i4.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = pop_exp(0);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      bad = (i4.out_valid !== 1'b1) || (i4.in_ready !== 1'b0)
         || (i4.d !== e.d) || (i4.bout !== e.bout)
         || (i4.ovf !== e.ovf);
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
      bad = bad || (i4.zero !== 1'b1);
`endif
      if (bad) begin
        errs++;
        $display("FAIL stall got v=%b r=%b d=%h want 1 0 %h",
                 i4.out_valid, i4.in_ready, i4.d, e.d);
      end
    end
    i4.in_valid = 1'b0;
    i4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i4.out_ready = 1'b0;
    checks++;
    if (i4.out_valid !== 1'b0 || i4.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL release got v=%b r=%b want 0 1",
               i4.out_valid, i4.in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    i4.a = 16'h1234; i4.b = 16'h0234; i4.bin = 1'b0;
    i4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i4.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (i4.in_ready !== 1'b1 || i4.out_valid !== 1'b0
        || i4.d !== 16'h0) begin
      errs++;
      $display("FAIL midrun_rst got r=%b v=%b d=%h want 1 0 0",
               i4.in_ready, i4.out_valid, i4.d);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run4("post_rst", 16'h0010, 16'h0001, 1'b0);
  endtask

  task automatic test_sweep();
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    int          lat[3];
    int          want[3];
    res_t        e;
    res_t        o;
    want[0] = 4; want[1] = 16; want[2] = 1;
    i4.out_ready = 1'b1;
    i1.out_ready = 1'b1;
    i16.out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom);
      if (n == 0) begin a = 16'h0000; b = 16'hFFFF; bin = 1; end
      i4.a = a;  i4.b = b;  i4.bin = bin;
      i1.a = a;  i1.b = b;  i1.bin = bin;
      i16.a = a; i16.b = b; i16.bin = bin;
      i4.in_valid = 1; i1.in_valid = 1; i16.in_valid = 1;
      q4.push_back(model(a, b, bin));
      q1.push_back(model(a, b, bin));
      q16.push_back(model(a, b, bin));
      @(posedge clk);
      @(negedge clk);
      i4.in_valid = 0; i1.in_valid = 0; i16.in_valid = 0;
      for (int k = 0; k < 3; k++) lat[k] = 0;
      for (int c = 1; c <= 24; c++) begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (lat[k] == 0 && ovld(k)) begin
            lat[k] = c;
            e = pop_exp(k);
            o = obs(k);
            checks++;
            if (o.d !== e.d || o.bout !== e.bout
                || o.ovf !== e.ovf) begin
              errs++;
              $display("FAIL sweep%0d got %h %b %b want %h %b %b",
                       k, o.d, o.bout, o.ovf, e.d, e.bout, e.ovf);
            end
`ifdef BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            checks++;
            if (o.zero !== e.zero) begin
              errs++;
              $display("FAIL sweep%0d_zero got %b want %b",
                       k, o.zero, e.zero);
            end
`endif
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lat[k] != want[k]) begin
          errs++;
          $display("FAIL sweep%0d_lat got %0d want %0d",
                   k, lat[k], want[k]);
        end
      end
    end
    idle_all();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_midrun();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/bit16_serial_subtractor.md
Name: bit16_serial_subtractor

Overview:
Multi-cycle two's-complement subtractor, the inverse operation of the team's 16-bit ripple adder. It computes d = a - b - bin. Each cycle it processes SLICE bits through a short borrow-ripple chain, and a registered borrow is carried between slices. Valid/ready handshakes on both sides let it sit between an operand source and a result consumer in the datapath, in place of a wide combinational subtract on timing-critical paths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
SLICE, 4, bits processed per cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  operands a, b, bin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in.
out_valid  output  1  result d, bout, ovf are valid.
out_ready  input  1  consumer accepts the result.
d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
bout  output  1  borrow-out; 1 when unsigned a < b + bin.
ovf  output  1  signed overflow.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, d=0, bout=0, ovf=0, slice counter=0, borrow register=0, operand registers=0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b, and bin (bin goes into the borrow register). Clear d and counter. Go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: compute slice k = counter, bits [k*SLICE +: SLICE], with the borrow register as borrow-in.
  - Write the slice difference into d[k*SLICE +: SLICE], update the borrow register, and increment counter.
  - On the edge processing slice N-1 (N = WIDTH/SLICE), go to DONE, set bout=final borrow, set ovf=(a[MSB]!=b[MSB]) && (d_new[MSB]!=a[MSB]), and set out_valid=1.
- Latency: out_valid rises exactly N edges after the accepting edge (N=4 at defaults; N=1 when SLICE=WIDTH).
- DONE:
  - out_valid=1, in_ready=0.
  - d, bout and ovf are held stable while out_ready=0, for an unbounded stall.
  - On out_valid&&out_ready, clear out_valid and go to IDLE. in_ready=1 the following cycle.
  - No accept in the same cycle as result handoff: one bubble between operations.
- in_valid while busy is ignored; the operands are not captured. The source must hold them until in_ready.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded.
- Arithmetic: pure modulo-2^WIDTH. bout and ovf are independent. Example: 0x0000-0x0001 gives bout=1, ovf=0.
- d bits not yet computed read 0 during RUN; only values with out_valid=1 are meaningful.

Optional Feature:
- Macro: BIT16_SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit), registered with the result in DONE.
  - zero=1 iff the final d==0.
  - Reset value 0; held while out_valid=1.
  - Computed as an OR-accumulate over slices, not a final WIDTH-wide NOR.
- Undefined: port absent, no accumulate logic. All other behaviour identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - the localparam computing N=WIDTH/SLICE;
  - the counter width function clog2(N), minimum 1.
- One sub-module, sub_slice: combinational SLICE-bit ripple-borrow subtractor built from full-subtractor cells.
  - Inputs x, y, bin; outputs diff, bout.
  - Instantiated once in the top; its output is muxed into d by the slice counter.

Test Plan:
- a=0x1234, b=0x0234, bin=0 -> after 4 cycles d=0x1000, bout=0, ovf=0 (zero=0 if enabled).
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0. Repeat with a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1.
- a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF -> d=0x8000, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after a=0xABCD, b=0xABCD -> d=0x0000 stable (zero=1 if enabled), in_ready=0 throughout. Then out_ready=1 -> out_valid falls, in_ready=1 the next cycle.
- Reset: assert rst during the 2nd RUN cycle -> in_ready=1, out_valid=0, d=0 immediately. A new operation a=0x0010, b=0x0001 -> d=0x000F.
- Parameter sweep SLICE=1, 4 and 16 with random operands -> out_valid latency 16, 4 and 1 edges respectively, and results match the golden model a-b-bin.
